// File: rtl/data_ram_1r1w_fwd.sv
// Byte-lane 1R1W data RAM with write-first forwarding and a post-reset zeroing sequencer.
// Read latency 1 cycle (OREG=0) or 2 (OREG=1); no backpressure, port inputs are ignored while init_busy.
module data_ram_1r1w_fwd #(
   parameter int DWIDTH     = 12,
   parameter int NLANE      = 4,
   parameter int OREG       = 0,
   parameter int CLR_ON_RST = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DWIDTH-1:0]    ram_radr,
   input  logic                 ram_ren,
   output logic [8*NLANE-1:0]   ram_rdata,
   output logic                 ram_rvalid,
   input  logic [DWIDTH-1:0]    ram_wadr,
   input  logic [8*NLANE-1:0]   ram_wdata,
   input  logic [NLANE-1:0]     ram_wen,
   output logic                 init_busy
);

   localparam int DEPTH = 2**DWIDTH;
   localparam int W     = 8*NLANE;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t              state;
   logic [DWIDTH-1:0]   clr_cnt;
   logic                busy;

   logic                run;
   logic                clr_we;
   logic                rd_en;

   logic                rd_vld1;
   logic [NLANE-1:0]    fwd_lane;
   logic [W-1:0]        fwd_dat;
   logic [NLANE-1:0][7:0] rd_raw;
   logic [NLANE-1:0][7:0] rd_mux;

   // Sequencer: the clear walks every address once, the last write coincides with the move to RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= (CLR_ON_RST != 0) ? CLEAR : RUN;
         clr_cnt <= '0;
         busy    <= (CLR_ON_RST != 0);
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (&clr_cnt) begin
            state <= RUN;
            busy  <= 1'b0;
         end
      end
   end

   assign init_busy = busy;
   assign run       = rst_n && (state == RUN);
   assign clr_we    = rst_n && (state == CLEAR);
   assign rd_en     = run && ram_ren;

   // Forwarding decision is registered with the read so the output mux needs no address compare.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_vld1  <= 1'b0;
         fwd_lane <= '0;
         fwd_dat  <= '0;
      end else begin
         rd_vld1 <= rd_en;
         if (rd_en) begin
            fwd_lane <= (ram_radr == ram_wadr) ? ram_wen : '0;
            fwd_dat  <= ram_wdata;
         end
      end
   end

   for (genvar k = 0; k < NLANE; k++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte;

      always_ff @(posedge clk) begin
         if (clr_we)
            mem[clr_cnt] <= '0;
         else if (run && ram_wen[k])
            mem[ram_wadr] <= ram_wdata[8*k +: 8];
      end

      // Read-before-write array port; the same-cycle new byte comes from the forwarding path.
      always_ff @(posedge clk) begin
         if (!rst_n)
            rd_byte <= '0;
         else if (rd_en)
            rd_byte <= mem[ram_radr];
      end

      assign rd_raw[k] = rd_byte;
      assign rd_mux[k] = fwd_lane[k] ? fwd_dat[8*k +: 8] : rd_raw[k];
   end

   if (OREG != 0) begin : g_oreg
      logic [W-1:0] rdata2;
      logic         rvalid2;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rdata2  <= '0;
            rvalid2 <= 1'b0;
         end else begin
            rvalid2 <= rd_vld1;
            if (rd_vld1)
               rdata2 <= rd_mux;
         end
      end

      assign ram_rdata  = rdata2;
      assign ram_rvalid = rvalid2;
   end else begin : g_noreg
      assign ram_rdata  = rd_mux;
      assign ram_rvalid = rd_vld1;
   end

endmodule

// File: tb/tb_data_ram_1r1w_fwd.sv
// Bench: two instances (16-word OREG=0, 1024-word OREG=1) share stimulus; a word-level model feeds per-instance scoreboards.
module tb_data_ram_1r1w_fwd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ren;
   logic [9:0]  radr, wadr;
   logic [3:0]  wen;
   logic [31:0] wdata;

   logic [31:0] rdata0, rdata1;
   logic        rvalid0, rvalid1, busy0, busy1;

   always #5 clk = ~clk;

   data_ram_1r1w_fwd #(.DWIDTH(4), .NLANE(4), .OREG(0), .CLR_ON_RST(1)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .ram_radr(radr[3:0]), .ram_ren(ren), .ram_rdata(rdata0), .ram_rvalid(rvalid0),
      .ram_wadr(wadr[3:0]), .ram_wdata(wdata), .ram_wen(wen), .init_busy(busy0)
   );

   data_ram_1r1w_fwd #(.DWIDTH(10), .NLANE(4), .OREG(1), .CLR_ON_RST(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .ram_radr(radr), .ram_ren(ren), .ram_rdata(rdata1), .ram_rvalid(rvalid1),
      .ram_wadr(wadr), .ram_wdata(wdata), .ram_wen(wen), .init_busy(busy1)
   );

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] m0 [16];
   logic [31:0] m1 [1024];
   int          rem [2];
   logic [31:0] last [2];
   int          cyc = 0;
   bit          rst_edge = 1'b1;
   int          checks = 0;
   int          failures = 0;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++)
         if (we[k]) r[8*k +: 8] = nw[8*k +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: the write lands first, then the read sees the updated word (write-first).
   always @(posedge clk) begin
      cyc++;
      rst_edge = !rst_n;
      if (!rst_n) begin
         rem[0] = 16;
         rem[1] = 1024;
         q0.delete();
         q1.delete();
         foreach (m0[i]) m0[i] = '0;
         foreach (m1[i]) m1[i] = '0;
      end else begin
         if (rem[0] > 0) rem[0]--;
         else begin
            m0[wadr[3:0]] = merge(m0[wadr[3:0]], wdata, wen);
            if (ren) q0.push_back('{m0[radr[3:0]], cyc});
         end
         if (rem[1] > 0) rem[1]--;
         else begin
            m1[wadr] = merge(m1[wadr], wdata, wen);
            if (ren) q1.push_back('{m1[radr], cyc + 1});
         end
      end
   end

   task automatic mon(input int d, input logic v, input logic [31:0] rd, input logic b);
      exp_t e;
      bit   due;
      chk($sformatf("dut%0d init_busy", d), {31'b0, b}, {31'b0, rem[d] > 0});
      if (rst_edge) begin
         chk($sformatf("dut%0d reset rvalid", d), {31'b0, v}, 32'd0);
         chk($sformatf("dut%0d reset rdata", d), rd, 32'd0);
         last[d] = '0;
      end else begin
         due = 1'b0;
         if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin due = 1'b1; e = q0.pop_front(); end
         if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin due = 1'b1; e = q1.pop_front(); end
         if (due) begin
            chk($sformatf("dut%0d rvalid", d), {31'b0, v}, 32'd1);
            chk($sformatf("dut%0d rdata", d), rd, e.d);
            last[d] = e.d;
         end else begin
            chk($sformatf("dut%0d idle rvalid", d), {31'b0, v}, 32'd0);
            chk($sformatf("dut%0d rdata hold", d), rd, last[d]);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, rvalid0, rdata0, busy0);
      mon(1, rvalid1, rdata1, busy1);
   end

   task automatic step(input logic r, input logic [9:0] ra, input logic [3:0] we,
                       input logic [9:0] wa, input logic [31:0] wd);
      ren = r; radr = ra; wen = we; wadr = wa; wdata = wd;
      @(posedge clk); #1;
      ren = 1'b0; wen = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, '0, '0, '0);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic count_clear0();
      int n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy0) n++;
         else break;
      end
      chk("dut0 clear length", n, 16);
      @(posedge clk); #1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while ((busy0 || busy1) && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("init_busy timeout", {31'b0, busy0 | busy1}, 32'd0);
   endtask

   initial begin
      logic [9:0] a, b;
      rst_n = 1'b0; ren = 1'b0; wen = '0; radr = '0; wadr = '0; wdata = '0;

      // Initial clear, then preload a nonzero pattern and clear again.
      do_reset(2);
      count_clear0();
      wait_ready();
      for (int i = 0; i < 16; i++) step(1'b0, '0, 4'hF, 10'(i), 32'hC0DE0000 + i);
      do_reset(2);
      count_clear0();
      wait_ready();
      for (int i = 0; i < 16; i++) step(1'b1, 10'(i), '0, '0, '0);
      idle(3);

      // Reset reasserted mid-clear; a write attempted during clear must not land.
      do_reset(2);
      idle(2);
      step(1'b1, 10'd9, 4'hF, 10'd9, 32'h5A5A5A5A);
      idle(3);
      do_reset(1);
      count_clear0();
      wait_ready();
      step(1'b1, 10'd9, '0, '0, '0);
      idle(3);

      // Byte-lane write.
      step(1'b0, '0, 4'b1111, 10'h005, 32'h11223344);
      step(1'b0, '0, 4'b0101, 10'h005, 32'hAABBCCDD);
      step(1'b1, 10'h005, '0, '0, '0);
      idle(3);

      // Same-cycle forwarding.
      step(1'b0, '0, 4'b1111, 10'h010, 32'h01020304);
      step(1'b1, 10'h010, 4'b1001, 10'h010, 32'hF0E0D0C0);
      idle(1);
      step(1'b1, 10'h010, '0, '0, '0);
      idle(3);

      // Streaming reads.
      for (int i = 0; i < 3; i++) step(1'b0, '0, 4'hF, 10'(i), 32'hA0 + i);
      idle(1);
      for (int i = 0; i < 3; i++) step(1'b1, 10'(i), '0, '0, '0);
      idle(4);

      // Independent ports.
      step(1'b0, '0, 4'hF, 10'h000, 32'h12345678);
      step(1'b1, 10'h000, 4'hF, 10'h3FF, 32'hDEADBEEF);
      step(1'b1, 10'h3FF, '0, '0, '0);
      idle(3);

      // Random traffic over a small address window to provoke collisions.
      for (int i = 0; i < 600; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
         b = ($urandom_range(0, 2) == 0) ? a : 10'($urandom_range(0, 15));
         step(1'($urandom), a, 4'($urandom), b, $urandom);
      end
      idle(5);

      chk("dut0 scoreboard drained", q0.size(), 32'd0);
      chk("dut1 scoreboard drained", q1.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_ram_1r1w_fwd.md
Name: data_ram_1r1w_fwd

Overview:
- Parametrised successor to the MA-stage byte-lane data RAM, with one read port and one write port.
- Lane count and depth are configurable.
- Adds read enable with a valid flag, write-first forwarding per byte lane, an optional output register stage, and a post-reset hardware clear sequencer.
- Sits in the MA stage between the load/store unit and the write-back stage.

Parameters:
- DWIDTH, 12, word address width; depth = 2**DWIDTH words.
- NLANE, 4, byte lanes per word; data width = 8*NLANE.
- OREG, 0, 0: read latency 1 cycle; 1: extra output register, read latency 2 cycles.
- CLR_ON_RST, 1, 1: zero the whole array after reset; 0: skip clearing, contents undefined.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- ram_radr  input  DWIDTH  read word address.
- ram_ren  input  1  read request.
- ram_rdata  output  8*NLANE  read data; lane k = bits [8k+7:8k].
- ram_rvalid  output  1  ram_rdata holds the result of a read request.
- ram_wadr  input  DWIDTH  write word address.
- ram_wdata  input  8*NLANE  write data.
- ram_wen  input  NLANE  per-lane byte write enables.
- init_busy  output  1  clear sequence in progress; ports are not accepted.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - ram_rdata=0, ram_rvalid=0, pipeline valid bits=0.
  - Clear counter=0.
  - FSM goes to CLEAR if CLR_ON_RST=1, else RUN.
  - Array contents are not touched by reset itself.
- FSM states:
  - CLEAR: each cycle, write 0 to all lanes at counter address, then counter+1. At counter = 2**DWIDTH-1 the write happens and the FSM moves to RUN next cycle. A full clear takes exactly 2**DWIDTH cycles after reset release.
  - RUN: normal operation; stays in RUN until reset.
  - Reset asserted mid-CLEAR restarts the clear from address 0.
- init_busy:
  - Equals 1 in CLEAR, 0 in RUN.
  - Is 1 in the first cycle after a reset edge when CLR_ON_RST=1.
- Inputs during CLEAR:
  - ram_ren, ram_wen and addresses are ignored; no external writes land.
  - ram_rvalid stays 0.
- Write (RUN): at the clock edge, for each k with ram_wen[k]=1, lane k of word ram_wadr takes ram_wdata[8k+7:8k]. Other lanes are unchanged.
- Read (RUN, OREG=0):
  - ram_ren=1 at edge N gives ram_rdata/ram_rvalid=1 after edge N+1 is not used; the data is valid in the cycle following edge N, i.e. 1-cycle latency.
  - ram_rvalid is 0 in any cycle whose preceding edge had ram_ren=0.
  - ram_rdata holds its previous value when no read occurs; it is not zeroed.
- Read (OREG=1):
  - Data and valid are delayed by one additional register stage, giving 2-cycle latency.
  - Back-to-back reads stream at 1 per cycle.
- Same-address forwarding (write-first, per lane):
  - Condition: ram_ren=1, ram_wen[k]=1 and ram_radr==ram_wadr at the same edge.
  - Returned lane k = the new ram_wdata lane k; lanes with wen=0 return the old stored bytes.
- Read-after-write to the same address at a later edge returns the written data; no hazard window exists.
- Different addresses: read and write are fully independent in the same cycle.
- Address wrap: addresses are taken modulo 2**DWIDTH with natural width truncation; no out-of-range detection.
- Storage is one array per lane, suitable for block-RAM inference. Forwarding uses a registered compare plus byte mux on the output.

Test Plan:
- Clear sequence: DWIDTH=4, CLR_ON_RST=1. Preload a nonzero pattern, hold rst_n=0 for 2 cycles, release.
  -> init_busy=1 for exactly 16 cycles then 0.
  -> Reading addresses 0..15 returns 0x00000000 with ram_rvalid=1 after 1 cycle.
- Reset mid-clear: release reset, then reassert at clear cycle 7.
  -> Counter restarts; init_busy lasts 16 cycles after the second release.
  -> A write attempted at cycle 3 of CLEAR does not persist (address reads 0).
- Byte-lane write: write 0x11223344 at 0x005 with wen=4'b1111, then 0xAABBCCDD with wen=4'b0101.
  -> Read of 0x005 returns 0x11BB33DD.
- Forwarding: word 0x010 holds 0x01020304. Same cycle: read 0x010 and write 0xF0E0D0C0 with wen=4'b1001.
  -> rdata=0xF00203C0, rvalid=1 the next cycle.
  -> A later read returns 0xF00203C0.
- Latency/streaming, OREG=1: reads of 0,1,2 on consecutive edges, preloaded with 0xA0, 0xA1, 0xA2.
  -> rvalid is 0 for the first cycle, then 1 for 3 cycles with data 0xA0, 0xA1, 0xA2, then 0.
  -> rdata holds 0xA2 afterwards.
- Independent ports: write 0xDEADBEEF at 0x3FF while reading 0x000 (holding 0x12345678) in the same cycle.
  -> rdata=0x12345678.
  -> The next read of 0x3FF returns 0xDEADBEEF.
